test_monitor: RTL and testbench

TEST_MONITOR -- requirements
Module: test_monitor

---
 rtl/test_monitor.sv | 162 ++++++++++++++++
 tb/tb_test_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/test_monitor.sv
// test_monitor
// Watches the register-file write-back port of a core running a
// self-checking test program and reports the verdict. The program writes
// its test number to x3 (gp), its result to x27 (1 = pass) and signals the
// end by writing 1 to x26. After a settle window the monitor latches PASS
// or FAIL and freezes all of its outputs until reset.
//
// Optional watchdog: define TEST_MONITOR_TIMEOUT_EN to enable the TIMEOUT
// state. When it is undefined, no watchdog logic is built and timeout_o
// is tied to 0.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   wb_we_i      write-back enable
//   wb_waddr_i   write-back destination register index
//   wb_wdata_i   write-back data
//   pc_i         current fetch PC
//   done_o       program finished (pass or fail)
//   pass_o       finished with x27 == 1
//   fail_o       finished with x27 != 1
//   timeout_o    watchdog expired before the program finished
//   test_num_o   last value written to x3
//   fail_pc_o    pc_i captured at the evaluation edge
//   cycle_cnt_o  cycles spent in RUN plus SETTLE (saturating)
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | one cycle after reset release
// ST_RUN     | test program running, waiting for the x26 done flag
// ST_SETTLE  | done flag seen, counting down before evaluation
// ST_PASS    | finished, x27 == 1 (sticky)
// ST_FAIL    | finished, x27 != 1 (sticky)
// ST_TIMEOUT | watchdog expired (sticky)

module test_monitor #(
    parameter int unsigned SETTLE_CYCLES  = 5,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_wdata_i,
    input  logic [31:0] pc_i,
    output logic        done_o,
    output logic        pass_o,
    output logic        fail_o,
    output logic        timeout_o,
    output logic [31:0] test_num_o,
    output logic [31:0] fail_pc_o,
    output logic [31:0] cycle_cnt_o
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_PASS    = 3'd3;
    localparam logic [2:0] ST_FAIL    = 3'd4;
    localparam logic [2:0] ST_TIMEOUT = 3'd5;

    localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [31:0] settle_cnt;
    logic        pass_flag;
    logic        pass_flag_nxt;

    logic wr_valid;
    logic wr_x3;
    logic wr_x27;
    logic wr_done_flag;
    logic active;
    logic settle_done;
    logic cycle_sat;
    logic timeout_hit;

    assign wr_valid     = wb_we_i && (wb_waddr_i != 5'd0);
    assign wr_x3        = wr_valid && (wb_waddr_i == 5'd3);
    assign wr_x27       = wr_valid && (wb_waddr_i == 5'd27);
    assign wr_done_flag = wr_valid && (wb_waddr_i == 5'd26) && (wb_wdata_i == 32'd1);

    assign active      = (state == ST_RUN) || (state == ST_SETTLE);
    assign settle_done = (state == ST_SETTLE) && (settle_cnt == 32'd0);
    assign cycle_sat   = (cycle_cnt_o == 32'hFFFF_FFFF);

    // A result written in the final settle cycle must still count, so the
    // evaluation looks at the flag value being written this cycle.
    assign pass_flag_nxt = (active && wr_x27) ? (wb_wdata_i == 32'd1) : pass_flag;

`ifdef TEST_MONITOR_TIMEOUT_EN
    // Fires on the edge where the cycle counter would reach the limit.
    assign timeout_hit = active && !cycle_sat &&
                         ((cycle_cnt_o + 32'd1) == 32'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = ST_RUN;
            ST_RUN: begin
                if (timeout_hit)       state_nxt = ST_TIMEOUT;
                else if (wr_done_flag) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Completion takes priority over a coincident timeout.
                if (settle_done)       state_nxt = pass_flag_nxt ? ST_PASS : ST_FAIL;
                else if (timeout_hit)  state_nxt = ST_TIMEOUT;
            end
            default:   state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            settle_cnt  <= 32'd0;
            pass_flag   <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            test_num_o  <= 32'd0;
            fail_pc_o   <= 32'd0;
            cycle_cnt_o <= 32'd0;
        end else begin
            state  <= state_nxt;
            // Status flags are registered alongside the state so that done_o
            // rises on the evaluation edge itself.
            done_o <= (state_nxt == ST_PASS) || (state_nxt == ST_FAIL) ||
                      (state_nxt == ST_TIMEOUT);
            pass_o <= (state_nxt == ST_PASS);
            fail_o <= (state_nxt == ST_FAIL);

            if (active) begin
                pass_flag <= pass_flag_nxt;
                if (wr_x3)      test_num_o  <= wb_wdata_i;
                if (!cycle_sat) cycle_cnt_o <= cycle_cnt_o + 32'd1;
            end

            if (state == ST_RUN && state_nxt == ST_SETTLE)
                settle_cnt <= SETTLE_LOAD;
            else if (state == ST_SETTLE && settle_cnt != 32'd0)
                settle_cnt <= settle_cnt - 32'd1;

            if (settle_done)
                fail_pc_o <= pc_i;
        end
    end

`ifdef TEST_MONITOR_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) timeout_o <= 1'b0;
        else     timeout_o <= (state_nxt == ST_TIMEOUT);
    end
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_test_monitor.sv
module tb_test_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic [31:0] pc_i;
    logic        done_o;
    logic        pass_o;
    logic        fail_o;
    logic        timeout_o;
    logic [31:0] test_num_o;
    logic [31:0] fail_pc_o;
    logic [31:0] cycle_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef TEST_MONITOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    test_monitor #(.SETTLE_CYCLES(5), .TIMEOUT_CYCLES(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_we_i     (wb_we_i),
        .wb_waddr_i  (wb_waddr_i),
        .wb_wdata_i  (wb_wdata_i),
        .pc_i        (pc_i),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .fail_o      (fail_o),
        .timeout_o   (timeout_o),
        .test_num_o  (test_num_o),
        .fail_pc_o   (fail_pc_o),
        .cycle_cnt_o (cycle_cnt_o)
    );

    typedef struct {
        logic [31:0] x3;
        logic [31:0] x27;
        logic [31:0] pc;
        logic [31:0] x26;
        logic        exp_done;
        logic        exp_pass;
        logic        exp_fail;
        logic [31:0] exp_tn;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        wb_we_i    = 1'b1;
        wb_waddr_i = addr;
        wb_wdata_i = data;
        tick();
        wb_we_i    = 1'b0;
        wb_waddr_i = 5'd0;
        wb_wdata_i = 32'd0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " done"},     {31'd0, done_o},    32'd0);
        chk({tag, " pass"},     {31'd0, pass_o},    32'd0);
        chk({tag, " fail"},     {31'd0, fail_o},    32'd0);
        chk({tag, " timeout"},  {31'd0, timeout_o}, 32'd0);
        chk({tag, " test_num"}, test_num_o,         32'd0);
        chk({tag, " fail_pc"},  fail_pc_o,          32'd0);
        chk({tag, " cycles"},   cycle_cnt_o,        32'd0);
    endtask

    // Leaves the DUT in RUN with cycle_cnt_o == 0.
    task automatic do_reset();
        rst        = 1'b1;
        wb_we_i    = 1'b0;
        wb_waddr_i = 5'd0;
        wb_wdata_i = 32'd0;
        pc_i       = 32'd0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{32'd7,          32'd1, 32'h0000_0100, 32'd1, 1'b1, 1'b1, 1'b0, 32'd7,          32'h0000_0100};
        vecs[1] = '{32'd4,          32'd0, 32'h0000_0080, 32'd1, 1'b1, 1'b0, 1'b1, 32'd4,          32'h0000_0080};
        vecs[2] = '{32'd5,          32'd2, 32'h0000_0044, 32'd1, 1'b1, 1'b0, 1'b1, 32'd5,          32'h0000_0044};
        vecs[3] = '{32'd9,          32'd1, 32'h0000_0010, 32'd3, 1'b0, 1'b0, 1'b0, 32'd9,          32'd0};
        vecs[4] = '{32'hDEAD_BEEF,  32'd1, 32'hFFFF_FFFC, 32'd1, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF,  32'hFFFF_FFFC};

        // Table-driven verdict scenarios
        for (int i = 0; i < 5; i++) begin
            do_reset();
            wr(5'd3,  vecs[i].x3);
            wr(5'd27, vecs[i].x27);
            pc_i = vecs[i].pc;
            wr(5'd26, vecs[i].x26);
            for (int k = 0; k < 5; k++) tick();
            chk($sformatf("vec%0d done", i),     {31'd0, done_o}, {31'd0, vecs[i].exp_done});
            chk($sformatf("vec%0d pass", i),     {31'd0, pass_o}, {31'd0, vecs[i].exp_pass});
            chk($sformatf("vec%0d fail", i),     {31'd0, fail_o}, {31'd0, vecs[i].exp_fail});
            chk($sformatf("vec%0d test_num", i), test_num_o,      vecs[i].exp_tn);
            chk($sformatf("vec%0d fail_pc", i),  fail_pc_o,       vecs[i].exp_pc);
            // 3 write cycles + 5 settle/run cycles since RUN entry
            chk($sformatf("vec%0d cycles", i),   cycle_cnt_o,     32'd8);
        end

        // Exact latency: done rises on the 5th edge after the x26 write, then freezes
        do_reset();
        wr(5'd3, 32'd7);
        wr(5'd27, 32'd1);
        pc_i = 32'h0000_0200;
        wr(5'd26, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("latency edge%0d done", k), {31'd0, done_o}, 32'd0);
        end
        tick();
        chk("latency edge5 done", {31'd0, done_o}, 32'd1);
        chk("latency edge5 pass", {31'd0, pass_o}, 32'd1);
        chk("latency test_num",   test_num_o,      32'd7);
        pc_i = 32'h0000_0300;
        wr(5'd27, 32'd0);
        wr(5'd3,  32'd99);
        wr(5'd26, 32'd1);
        tick();
        chk("frozen pass",     {31'd0, pass_o}, 32'd1);
        chk("frozen fail",     {31'd0, fail_o}, 32'd0);
        chk("frozen test_num", test_num_o,      32'd7);
        chk("frozen fail_pc",  fail_pc_o,       32'h0000_0200);
        chk("frozen cycles",   cycle_cnt_o,     32'd8);

        // x27 rewritten to 1 two cycles after the done flag
        do_reset();
        wr(5'd27, 32'd0);
        wr(5'd26, 32'd1);
        tick();
        wr(5'd27, 32'd1);
        for (int k = 0; k < 3; k++) tick();
        chk("late x27 pass", {31'd0, pass_o}, 32'd1);
        chk("late x27 fail", {31'd0, fail_o}, 32'd0);

        // x27 written in the final settle cycle is used
        do_reset();
        wr(5'd27, 32'd0);
        wr(5'd26, 32'd1);
        for (int k = 0; k < 4; k++) tick();
        chk("final-cycle pre done", {31'd0, done_o}, 32'd0);
        wr(5'd27, 32'd1);
        chk("final-cycle pass", {31'd0, pass_o}, 32'd1);

        // Bad done flag values are ignored
        do_reset();
        wr(5'd26, 32'd2);
        wb_we_i = 1'b0; wb_waddr_i = 5'd26; wb_wdata_i = 32'd1;
        tick();
        wb_waddr_i = 5'd0; wb_wdata_i = 32'd0;
        for (int k = 0; k < 8; k++) tick();
        chk("ignored x26 done",   {31'd0, done_o}, 32'd0);
        chk("ignored x26 cycles", cycle_cnt_o,     32'd10);
        wr(5'd3, 32'd12);
        chk("still running test_num", test_num_o, 32'd12);

        // Watchdog (TIMEOUT_CYCLES = 20)
        do_reset();
        for (int k = 0; k < 19; k++) tick();
        chk("timeout early", {31'd0, timeout_o}, 32'd0);
        tick();
        chk("timeout at limit", {31'd0, timeout_o}, {31'd0, TO_EN});
        chk("timeout done",     {31'd0, done_o},    {31'd0, TO_EN});
        chk("timeout cycles",   cycle_cnt_o,        32'd20);
        for (int k = 0; k < 5; k++) tick();
        chk("timeout later",    {31'd0, timeout_o}, {31'd0, TO_EN});
        chk("timeout cycles later", cycle_cnt_o, TO_EN ? 32'd20 : 32'd25);

        // Reset in the middle of SETTLE, then a fresh pass run
        do_reset();
        wr(5'd3, 32'd6);
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("mid-settle rst");
        tick();
        chk("mid-settle rst hold done", {31'd0, done_o}, 32'd0);
        rst = 1'b0;
        tick();
        wr(5'd3, 32'd11);
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        for (int k = 0; k < 5; k++) tick();
        chk("rerun pass",     {31'd0, pass_o}, 32'd1);
        chk("rerun test_num", test_num_o,      32'd11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
